// File: rtl/spi_master_tx_pkg.sv
// Shared SPI definitions: the frame state encoding and the default word width,
// used by the master transmit path and the slave side.
package spi_master_tx_pkg;

  localparam int unsigned SPI_DATA_WIDTH = 12;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOW   = 3'd1,
    ST_HIGH  = 3'd2,
    ST_TRAIL = 3'd3,
    ST_GAP   = 3'd4
  } spi_state_e;

endpackage

// File: rtl/spi_master_tx_clk_div.sv
// sck half-period timer: counts 0..CLK_DIV-1 while enabled and strobes phase_end_o
// on the last count. clr_i restarts the count whenever the frame FSM changes state.
module spi_master_tx_clk_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic phase_end_o
);

  localparam int unsigned    CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // next count: held at zero when idle or on a state change
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || clr_i) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // count register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign phase_end_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/spi_master_tx.sv
// SPI mode-0 master transmitter: shifts DATA_WIDTH-bit words out MSB first on mosi,
// generating sck and active-low ssel, with a valid/ready input and a done pulse.
module spi_master_tx
  import spi_master_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SPI_DATA_WIDTH,
  parameter int unsigned CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  sck,
  output logic                  ssel,
  output logic                  mosi,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned   BW       = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  spi_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  sck_q, sck_d;
  logic                  ssel_q, ssel_d;
  logic                  mosi_q, mosi_d;
  logic                  done_q, done_d;
  logic                  phase_end_s;
  logic                  state_chg_s;

  assign state_chg_s = (state_d != state_q);

  spi_master_tx_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk         (clk),
    .rst         (rst),
    .en_i        (state_q != ST_IDLE),
    .clr_i       (state_chg_s),
    .phase_end_o (phase_end_s)
  );

  // frame sequencing; mosi only moves at accept or together with the sck fall
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    sck_d     = sck_q;
    ssel_d    = ssel_q;
    mosi_d    = mosi_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tx_valid) begin
          shift_d   = tx_data;
          mosi_d    = tx_data[DATA_WIDTH-1];
          ssel_d    = 1'b0;
          bit_cnt_d = '0;
          state_d   = ST_LOW;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_LOW: begin
        if (phase_end_s) begin
          sck_d   = 1'b1;
          state_d = ST_HIGH;
        end else begin
          state_d = ST_LOW;
        end
      end
      ST_HIGH: begin
        if (phase_end_s) begin
          sck_d     = 1'b0;
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == LAST_BIT) begin
            mosi_d  = 1'b0;
            state_d = ST_TRAIL;
          end else begin
            shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
            mosi_d  = shift_q[DATA_WIDTH-2];
            state_d = ST_LOW;
          end
        end else begin
          state_d = ST_HIGH;
        end
      end
      ST_TRAIL: begin
        if (phase_end_s) begin
          ssel_d  = 1'b1;
          done_d  = 1'b1;
          state_d = ST_GAP;
        end else begin
          state_d = ST_TRAIL;
        end
      end
      ST_GAP: begin
        if (phase_end_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_GAP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sck_d   = 1'b0;
        ssel_d  = 1'b1;
        mosi_d  = 1'b0;
      end
    endcase
  end

  // state and output registers; reset aborts any frame in flight
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      sck_q     <= 1'b0;
      ssel_q    <= 1'b1;
      mosi_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      sck_q     <= sck_d;
      ssel_q    <= ssel_d;
      mosi_q    <= mosi_d;
      done_q    <= done_d;
    end
  end

  assign tx_ready = (state_q == ST_IDLE);
  assign busy     = (state_q != ST_IDLE);
  assign sck      = sck_q;
  assign ssel     = ssel_q;
  assign mosi     = mosi_q;
  assign done     = done_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: two instances (CLK_DIV=4 and CLK_DIV=1) driven with fixed
// and random frames, checked cycle by cycle against a timing model of the frame.
module tb_spi_master_tx;

  localparam int DW = 12;
  localparam logic [5:0] IDLE_O = 6'b010010;  // {sck,ssel,mosi,done,ready,busy}

  logic clk = 1'b0;
  logic rst;
  logic [DW-1:0] tx_data_a, tx_data_b;
  logic tx_valid_a, tx_valid_b;
  logic rdy_a, sck_a, ssel_a, mosi_a, busy_a, done_a;
  logic rdy_b, sck_b, ssel_b, mosi_b, busy_b, done_b;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  spi_master_tx #(.DATA_WIDTH(DW), .CLK_DIV(4)) dut_a (
    .clk(clk), .rst(rst), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
    .tx_ready(rdy_a), .sck(sck_a), .ssel(ssel_a), .mosi(mosi_a),
    .busy(busy_a), .done(done_a)
  );

  spi_master_tx #(.DATA_WIDTH(DW), .CLK_DIV(1)) dut_b (
    .clk(clk), .rst(rst), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
    .tx_ready(rdy_b), .sck(sck_b), .ssel(ssel_b), .mosi(mosi_b),
    .busy(busy_b), .done(done_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // expected outputs k cycles after the accept edge, from the frame timing rules
  function automatic logic [5:0] model(input int k, input int cd, input logic [DW-1:0] w);
    int len = (2*DW + 2)*cd + 1;
    int p   = (k - 1) / cd;
    if (k >= len)     return IDLE_O;
    if (p < 2*DW)     return {p[0], 1'b0, w[DW-1-p/2], 3'b001};
    if (p == 2*DW)    return 6'b000001;
    return {3'b010, (k == (2*DW + 1)*cd + 1), 2'b01};
  endfunction

  function automatic logic [5:0] obs_of(input bit sel);
    if (sel) return {sck_b, ssel_b, mosi_b, done_b, rdy_b, busy_b};
    return {sck_a, ssel_a, mosi_a, done_a, rdy_a, busy_a};
  endfunction

  task automatic drive(input bit sel, input logic v, input logic [DW-1:0] d);
    if (sel) begin
      tx_valid_b = v; tx_data_b = d;
    end else begin
      tx_valid_a = v; tx_data_a = d;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_a", obs_of(1'b0), IDLE_O);
      check("idle_b", obs_of(1'b1), IDLE_O);
    end
  endtask

  // one frame from an IDLE negedge; hold keeps tx_valid up with nxt for back-to-back
  task automatic run_frame(input bit sel, input logic [DW-1:0] w, input bit hold,
                           input logic [DW-1:0] nxt, input bit poke, input int abort_k);
    int cd = sel ? 1 : 4;
    int len = (2*DW + 2)*cd + 1;
    logic [DW-1:0] rx = '0;
    int rises = 0;
    logic prev_sck = 1'b0, prev_mosi = 1'b0;
    logic [5:0] o;
    bit live = 1'b1;
    drive(sel, 1'b1, w);
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      o = obs_of(sel);
      if (live) begin
        if (abort_k > 0 && k == abort_k + 1) begin
          check("reset_mid_frame", o, IDLE_O);
          rst  = 1'b1;
          live = 1'b0;
        end else begin
          check($sformatf("cd%0d_k%0d", cd, k), o, model(k, cd, w));
          if (!prev_sck && o[5]) begin
            check("mosi_stable_on_rise", o[3], prev_mosi);
            rx = {rx[DW-2:0], o[3]};
            rises++;
          end
          prev_sck  = o[5];
          prev_mosi = o[3];
          if (k == 1) drive(sel, hold, hold ? nxt : 12'($urandom));
          if (poke && k == 20) drive(sel, 1'b1, 12'h123);
          if (poke && k == 21) drive(sel, 1'b0, 12'h123);
          if (abort_k > 0 && k == abort_k) rst = 1'b0;
        end
      end
    end
    if (abort_k == 0) begin
      check("rx_word", rx, w);
      check("rise_count", rises, DW);
    end
  endtask

  initial begin
    logic [DW-1:0] w, nxt;
    bit h;
    rst = 1'b0;
    drive(1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, '0);
    repeat (3) @(negedge clk);
    check("reset_a", obs_of(1'b0), IDLE_O);
    check("reset_b", obs_of(1'b1), IDLE_O);
    rst = 1'b1;
    idle(200);

    run_frame(1'b0, 12'hA5C, 1'b0, 12'h000, 1'b0, 0);
    idle(3);
    run_frame(1'b0, 12'hA5C, 1'b0, 12'h000, 1'b1, 0);
    idle(2);
    run_frame(1'b0, 12'hFFF, 1'b1, 12'h001, 1'b0, 0);
    run_frame(1'b0, 12'h001, 1'b0, 12'h000, 1'b0, 0);
    idle(2);
    run_frame(1'b0, 12'hA5C, 1'b0, 12'h000, 1'b0, 40);
    idle(10);
    run_frame(1'b0, 12'h3C3, 1'b0, 12'h000, 1'b0, 0);
    idle(2);

    // reset coincident with tx_valid must not start a frame
    rst = 1'b0;
    drive(1'b0, 1'b1, 12'hABC);
    @(negedge clk);
    check("rst_vs_valid", obs_of(1'b0), IDLE_O);
    rst = 1'b1;
    drive(1'b0, 1'b0, 12'h000);
    idle(3);

    run_frame(1'b1, 12'h555, 1'b0, 12'h000, 1'b0, 0);
    idle(2);

    for (int s = 0; s < 2; s++) begin
      w = 12'($urandom);
      for (int i = 0; i < 8; i++) begin
        nxt = 12'($urandom);
        h   = (i == 7) ? 1'b0 : 1'($urandom);
        run_frame(1'(s), w, h, nxt, 1'b0, 0);
        if (!h) idle($urandom_range(0, 4));
        w = nxt;
      end
      idle(2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
